ahb_slave_mem: RTL and testbench
================================

Name: ahb_slave_mem

Overview:
AHB responder: a zero- or multi-wait-state SRAM-backed slave that terminates transfers issued by the team's AHB master.
- Sits behind the bus decoder/mux and is selected by i_hsel.
- Gives the master pipeline a real target for read/write and ERROR-path testing.
- Never issues RETRY or SPLIT.

Parameters:
BUS_WDT, 32, data bus width; 32 or 64 only.
ADDR_WDT, 10, log2 of memory size in bytes; depth = 2^ADDR_WDT / (BUS_WDT/8) words.
WAIT_STATES, 0, wait cycles inserted in every OKAY data phase; range 0..15.

Ports:
i_hclk  in  1  clock, rising edge.
i_hreset_n  in  1  reset, asynchronous, active-low.
i_hsel  in  1  slave select from decoder.
i_haddr  in  32  address.
i_htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
i_hwrite  in  1  1 = write.
i_hsize  in  2  0 = byte, 1 = half, 2 = word, 3 = dword.
i_hburst  in  2  accepted, ignored.
i_hprot  in  4  accepted, ignored.
i_hwdata  in  BUS_WDT  write data, data phase.
i_hready  in  1  bus-wide HREADY, muxed back from all slaves.
o_hready  out  1  this slave's HREADYOUT.
o_hresp  out  2  OKAY=0, ERROR=1; RETRY/SPLIT never driven.
o_hrdata  out  BUS_WDT  read data.

Behaviour:
Reset and idle outputs:
- Reset values: o_hready=1, o_hresp=OKAY, o_hrdata=0, state=ST_IDLE, wait counter=0.
- Memory contents are not reset.

Address phase accept:
- Accept = i_hsel && i_hready && i_htrans[1] (NONSEQ or SEQ).
- On accept, register addr[ADDR_WDT-1:0], hwrite, hsize, plus an error flag.
- Upper address bits are ignored; the address aliases modulo the memory size.
- IDLE/BUSY, or i_hsel=0 with i_hready=1: no data phase. Outputs stay/return to o_hready=1, OKAY.

Error flag:
- Set if hsize exceeds the bus width (hsize=3 with BUS_WDT=32).
- Set if the address is unaligned to hsize: half needs addr[0]=0; word needs addr[1:0]=0; dword needs addr[2:0]=0.

States:
- ST_IDLE: o_hready=1, OKAY. An accept goes to ST_ERR1 if the error flag is set. Otherwise it goes to ST_DATA with cnt=WAIT_STATES.
- ST_DATA: o_hready=(cnt==0), OKAY.
  - cnt!=0: cnt decrements each cycle.
  - cnt==0: the transfer completes this cycle, then the next state is decided like ST_IDLE. A pipelined accept in the same cycle is legal and required; back-to-back zero-wait transfers sustain one per cycle.
- ST_ERR1: o_hready=0, o_hresp=ERROR. Always goes to ST_ERR2.
- ST_ERR2: o_hready=1, o_hresp=ERROR. An address phase presented in this cycle is accepted normally; the master is also free to cancel it to IDLE.

Writes:
- Performed on the rising edge ending the final ST_DATA cycle, using i_hwdata.
- Byte-enable lanes come from hsize and the low address bits, little-endian.
- Lane index = addr[log2(BUS_WDT/8)-1:0]; lane count = 2^hsize.
- Unselected lanes are unchanged.
- Erroring writes never modify memory.

Reads:
- o_hrdata = full word at the registered word address, combinational from the array, during ST_DATA.
- The value is only guaranteed when o_hready=1.
- Full word is returned; the master selects lanes.
- Read-after-write to the same address in consecutive transfers returns the new data, because the write commits before the read data phase.
- o_hrdata holds its last value outside read data phases.

Other rules:
- Write data phases do not change o_hrdata.
- Reset asserted mid-transfer: immediate return to reset values; the in-flight write is dropped.

Test Plan:
- WAIT_STATES=0, BUS_WDT=32: NONSEQ write 0x100 = 0xDEADBEEF, then pipelined NONSEQ read 0x100 -> o_hready=1 every cycle; read data phase o_hrdata=0xDEADBEEF, o_hresp=0.
- Byte write 0x5A to 0x102 over 0xDEADBEEF, then word read 0x100 -> 0xDE5ABEEF.
- WAIT_STATES=3: read 0x040 -> o_hready low for exactly 3 cycles, high on the 4th with data; o_hresp=OKAY throughout.
- Word write to 0x101 (unaligned) -> ST_ERR1 cycle (hready=0, hresp=1), then ST_ERR2 (hready=1, hresp=1); a following read of 0x100 shows memory unchanged.
- hsize=3 with BUS_WDT=32 -> two-cycle ERROR; an IDLE transfer and an i_hsel=0 transfer -> o_hready=1, OKAY, no memory change.
- Assert reset during the 2nd wait state of a write (WAIT_STATES=3) -> o_hready=1, OKAY immediately; a read after reset release shows the target word unmodified.

Source files
------------

// File: rtl/ahb_slave_mem.sv
// AHB-Lite responder backed by a word-wide SRAM array with a fixed number of wait states
// on every OKAY data phase and a two-cycle ERROR response for illegal size/alignment.
module ahb_slave_mem #(
  parameter int unsigned BUS_WDT     = 32,
  parameter int unsigned ADDR_WDT    = 10,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic               i_hclk,
  input  logic               i_hreset_n,
  input  logic               i_hsel,
  input  logic [31:0]        i_haddr,
  input  logic [1:0]         i_htrans,
  input  logic               i_hwrite,
  input  logic [1:0]         i_hsize,
  input  logic [1:0]         i_hburst,
  input  logic [3:0]         i_hprot,
  input  logic [BUS_WDT-1:0] i_hwdata,
  input  logic               i_hready,
  output logic               o_hready,
  output logic [1:0]         o_hresp,
  output logic [BUS_WDT-1:0] o_hrdata
);

  localparam int unsigned NumBytes = BUS_WDT / 8;
  localparam int unsigned LaneW    = $clog2(NumBytes);
  localparam int unsigned WordAw   = ADDR_WDT - LaneW;
  localparam int unsigned Depth    = 2 ** WordAw;

  typedef enum logic [1:0] {StIdle, StData, StErr1, StErr2} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_WDT-1:0] addr_q;
  logic                write_q;
  logic [1:0]          size_q;
  logic [BUS_WDT-1:0]  rdata_q;
  logic [BUS_WDT-1:0]  mem [Depth];

  logic                accept, size_err, align_err, req_err, phase_end;
  logic                commit, read_phase;
  logic [WordAw-1:0]   word_idx;
  logic [NumBytes-1:0] byte_en;
  logic                unused;

  assign unused = ^{i_hburst, i_hprot, i_haddr[31:ADDR_WDT]};

  assign accept   = i_hsel & i_hready & i_htrans[1];
  assign size_err = (BUS_WDT == 32) && (i_hsize == 2'd3);
  assign req_err  = size_err | align_err;

  always_comb begin
    case (i_hsize)
      2'd1:    align_err = i_haddr[0];
      2'd2:    align_err = |i_haddr[1:0];
      2'd3:    align_err = |i_haddr[2:0];
      default: align_err = 1'b0;
    endcase
  end

  // Cycles in which a new address phase may be taken: idle, ERR2, or the last data cycle.
  assign phase_end = (state_q == StIdle) || (state_q == StErr2) ||
                     ((state_q == StData) && (cnt_q == 4'd0));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StData: if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      StErr1: state_d = StErr2;
      default: ;
    endcase
    if (phase_end) begin
      if (accept) begin
        state_d = req_err ? StErr1 : StData;
        cnt_d   = req_err ? 4'd0 : 4'(WAIT_STATES);
      end else begin
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 2'd0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (phase_end && accept) begin
        addr_q  <= i_haddr[ADDR_WDT-1:0];
        write_q <= i_hwrite;
        size_q  <= i_hsize;
      end
      if (read_phase) rdata_q <= mem[word_idx];
    end
  end

  always_comb begin
    o_hready = 1'b1;
    o_hresp  = 2'd0;
    unique case (state_q)
      StData: o_hready = (cnt_q == 4'd0);
      StErr1: begin
        o_hready = 1'b0;
        o_hresp  = 2'd1;
      end
      StErr2: o_hresp = 2'd1;
      default: ;
    endcase
  end

  assign word_idx   = addr_q[ADDR_WDT-1:LaneW];
  assign commit     = (state_q == StData) && (cnt_q == 4'd0) && write_q;
  assign read_phase = (state_q == StData) && !write_q;

  // Little-endian lanes: 2^size bytes starting at the low address bits.
  always_comb begin
    byte_en = '0;
    for (int i = 0; i < NumBytes; i++) begin
      byte_en[i] = (i >= int'(addr_q[LaneW-1:0])) &&
                   (i < int'(addr_q[LaneW-1:0]) + (1 << size_q));
    end
  end

  // State is reset asynchronously, so a reset mid-phase drops the pending commit.
  always_ff @(posedge i_hclk) begin
    if (commit) begin
      for (int i = 0; i < NumBytes; i++) begin
        if (byte_en[i]) mem[word_idx][8*i +: 8] <= i_hwdata[8*i +: 8];
      end
    end
  end

  assign o_hrdata = read_phase ? mem[word_idx] : rdata_q;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: a zero-wait and a three-wait instance driven by a pipelined
// master model, with a byte-level reference memory feeding an expected-read-data queue.
module tb_ahb_slave_mem;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [1:0]  trans;
    logic        sel;
  } xfer_t;

  logic        clk = 1'b0;
  logic        hreset_n;
  logic        hsel, act;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans, hsize, hburst;
  logic [3:0]  hprot;
  logic        hwrite;
  logic        hsel0, hsel3, rdy0, rdy3;
  logic [1:0]  resp0, resp3;
  logic [31:0] rdata0, rdata3;

  logic [7:0]  model [2][1024];
  logic [31:0] last_rd [2];
  xfer_t       xq[$];
  logic [31:0] exp_q[$];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  assign hsel0 = hsel & ~act;
  assign hsel3 = hsel & act;

  ahb_slave_mem #(.BUS_WDT(32), .ADDR_WDT(10), .WAIT_STATES(0)) u_dut0 (
    .i_hclk(clk), .i_hreset_n(hreset_n), .i_hsel(hsel0), .i_haddr(haddr),
    .i_htrans(htrans), .i_hwrite(hwrite), .i_hsize(hsize), .i_hburst(hburst),
    .i_hprot(hprot), .i_hwdata(hwdata), .i_hready(rdy0), .o_hready(rdy0),
    .o_hresp(resp0), .o_hrdata(rdata0)
  );

  ahb_slave_mem #(.BUS_WDT(32), .ADDR_WDT(10), .WAIT_STATES(3)) u_dut3 (
    .i_hclk(clk), .i_hreset_n(hreset_n), .i_hsel(hsel3), .i_haddr(haddr),
    .i_htrans(htrans), .i_hwrite(hwrite), .i_hsize(hsize), .i_hburst(hburst),
    .i_hprot(hprot), .i_hwdata(hwdata), .i_hready(rdy3), .o_hready(rdy3),
    .o_hresp(resp3), .o_hrdata(rdata3)
  );

  function automatic logic req_err(input logic [31:0] a, input logic [1:0] s);
    case (s)
      2'd1:    return a[0];
      2'd2:    return a[1:0] != 2'd0;
      2'd3:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    logic [31:0] w;
    for (int b = 0; b < 4; b++) w[8*b +: 8] = model[act][{a[9:2], 2'(b)}];
    return w;
  endfunction

  task automatic push(input logic [31:0] a, input logic w, input logic [1:0] s,
                      input logic [31:0] d, input logic [1:0] t = 2'd2,
                      input logic sl = 1'b1);
    xfer_t x;
    x = '{addr: a, wr: w, size: s, wdata: d, trans: t, sel: sl};
    xq.push_back(x);
  endtask

  // Pipelined master: address phase of xq[0] overlaps the data phase of the previous one.
  task automatic run_queue();
    xfer_t       cur;
    logic        dv, dwr, derr, rdy_s, rd_phase;
    logic [1:0]  resp_s;
    logic [31:0] dwd, rdata_s, exp_w;
    int          waits, ws, lane;
    dv = 1'b0; dwr = 1'b0; derr = 1'b0; dwd = '0; waits = 0;
    ws = act ? 3 : 0;
    while (xq.size() > 0 || dv) begin
      if (xq.size() > 0) begin
        haddr  = xq[0].addr;
        htrans = xq[0].trans;
        hwrite = xq[0].wr;
        hsize  = xq[0].size;
        hsel   = xq[0].sel;
      end else begin
        htrans = 2'd0;
        hsel   = 1'b0;
      end
      hwdata = dv ? dwd : 32'h0;
      @(negedge clk);
      rdy_s    = act ? rdy3 : rdy0;
      resp_s   = act ? resp3 : resp0;
      rdata_s  = act ? rdata3 : rdata0;
      rd_phase = dv && !dwr && !derr;
      if (dv) begin
        total++;
        if (resp_s !== {1'b0, derr}) begin
          bad++;
          $display("FAIL hresp addr=%h got=%0d want=%0d", haddr, resp_s, derr);
        end
        if (rdy_s) begin
          total++;
          if (waits != (derr ? 1 : ws)) begin
            bad++;
            $display("FAIL wait_count got=%0d want=%0d", waits, derr ? 1 : ws);
          end
          if (rd_phase) begin
            exp_w = exp_q.pop_front();
            total++;
            if (rdata_s !== exp_w) begin
              bad++;
              $display("FAIL read_data got=%h want=%h", rdata_s, exp_w);
            end
            last_rd[act] = exp_w;
          end
          dv = 1'b0;
        end else begin
          waits++;
          if (waits > 40) begin
            total++; bad++;
            $display("FAIL hready_timeout got=0 want=1");
            dv = 1'b0;
          end
        end
      end else begin
        total++;
        if (rdy_s !== 1'b1 || resp_s !== 2'd0) begin
          bad++;
          $display("FAIL idle_outputs got=%b/%0d want=1/0", rdy_s, resp_s);
        end
      end
      if (!rd_phase) begin
        total++;
        if (rdata_s !== last_rd[act]) begin
          bad++;
          $display("FAIL rdata_hold got=%h want=%h", rdata_s, last_rd[act]);
        end
      end
      @(posedge clk); #1;
      if (rdy_s && xq.size() > 0) begin
        cur = xq.pop_front();
        if (cur.sel && cur.trans[1]) begin
          dv = 1'b1; dwr = cur.wr; dwd = cur.wdata; waits = 0;
          derr = req_err(cur.addr, cur.size);
          lane = int'(cur.addr[1:0]);
          if (!derr) begin
            if (cur.wr) begin
              for (int b = 0; b < 4; b++) begin
                if (b >= lane && b < lane + (1 << cur.size))
                  model[act][{cur.addr[9:2], 2'(b)}] = cur.wdata[8*b +: 8];
              end
            end else begin
              exp_q.push_back(model_word(cur.addr));
            end
          end
        end
      end
    end
    htrans = 2'd0;
    hsel   = 1'b0;
  endtask

  task automatic test_reset();
    hreset_n = 1'b0; hsel = 1'b0; act = 1'b0; haddr = '0; htrans = 2'd0;
    hwrite = 1'b0; hsize = 2'd0; hburst = 2'd0; hprot = 4'd0; hwdata = '0;
    last_rd[0] = '0; last_rd[1] = '0;
    repeat (2) @(posedge clk);
    #2;
    total++;
    if (rdy0 !== 1'b1 || rdy3 !== 1'b1) begin
      bad++; $display("FAIL reset_hready got=%b%b want=11", rdy0, rdy3);
    end
    total++;
    if (resp0 !== 2'd0 || resp3 !== 2'd0) begin
      bad++; $display("FAIL reset_hresp got=%0d/%0d want=0/0", resp0, resp3);
    end
    total++;
    if (rdata0 !== 32'h0 || rdata3 !== 32'h0) begin
      bad++; $display("FAIL reset_hrdata got=%h/%h want=0/0", rdata0, rdata3);
    end
    hreset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    act = 1'b0;
    push(32'h100, 1'b1, 2'd2, 32'hDEADBEEF);
    push(32'h100, 1'b0, 2'd2, 32'h0);
    run_queue();
  endtask

  task automatic test_byte_lanes();
    act = 1'b0;
    push(32'h102, 1'b1, 2'd0, 32'h005A0000);
    push(32'h100, 1'b0, 2'd2, 32'h0);
    push(32'h104, 1'b1, 2'd2, 32'h01234567);
    push(32'h106, 1'b1, 2'd1, 32'hC3A50000);
    push(32'h104, 1'b1, 2'd0, 32'h000000EE);
    push(32'h104, 1'b0, 2'd2, 32'h0);
    run_queue();
    total++;
    if (last_rd[0] !== 32'hC3A545EE) begin
      bad++; $display("FAIL lane_merge got=%h want=c3a545ee", last_rd[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [1:0]  s;
    act = 1'b0;
    for (int i = 0; i < 8; i++) push(32'h200 + 32'(4 * i), 1'b1, 2'd2, $urandom);
    for (int i = 0; i < 8; i++) push(32'h200 + 32'(4 * i), 1'b0, 2'd2, 32'h0);
    for (int i = 0; i < 12; i++) begin
      s = 2'($urandom_range(0, 2));
      a = 32'h200 + 32'($urandom_range(0, 31));
      a = a & ~((32'd1 << s) - 32'd1);
      push(a, 1'b1, s, $urandom);
      push(a, 1'b0, 2'd2, 32'h0);
    end
    run_queue();
  endtask

  task automatic test_wait_states();
    act = 1'b1;
    push(32'h040, 1'b1, 2'd2, 32'hCAFEF00D);
    push(32'h040, 1'b0, 2'd2, 32'h0);
    push(32'h041, 1'b1, 2'd1, 32'hFFFFFFFF);
    push(32'h040, 1'b0, 2'd2, 32'h0);
    run_queue();
  endtask

  task automatic test_errors();
    act = 1'b0;
    push(32'h101, 1'b1, 2'd2, 32'hFFFFFFFF);
    push(32'h100, 1'b0, 2'd2, 32'h0);
    push(32'h108, 1'b1, 2'd3, 32'hAAAA5555);
    push(32'h100, 1'b1, 2'd2, 32'h11111111, 2'd0);
    push(32'h100, 1'b1, 2'd2, 32'h22222222, 2'd2, 1'b0);
    push(32'h103, 1'b1, 2'd1, 32'h33333333);
    push(32'h100, 1'b0, 2'd2, 32'h0);
    push(32'h104, 1'b0, 2'd2, 32'h0);
    run_queue();
  endtask

  task automatic test_reset_mid_write();
    act = 1'b1;
    haddr = 32'h040; hwrite = 1'b1; hsize = 2'd2; htrans = 2'd2; hsel = 1'b1;
    @(posedge clk); #1;
    htrans = 2'd0; hsel = 1'b0; hwdata = 32'h12345678;
    @(posedge clk); #2;
    hreset_n = 1'b0;
    #1;
    total++;
    if (rdy3 !== 1'b1 || resp3 !== 2'd0) begin
      bad++; $display("FAIL reset_mid_write got=%b/%0d want=1/0", rdy3, resp3);
    end
    total++;
    if (rdata3 !== 32'h0) begin
      bad++; $display("FAIL reset_mid_hrdata got=%h want=0", rdata3);
    end
    @(posedge clk); #1;
    hreset_n = 1'b1;
    last_rd[0] = '0; last_rd[1] = '0;
    @(posedge clk); #1;
    push(32'h040, 1'b0, 2'd2, 32'h0);
    run_queue();
    act = 1'b0;
    push(32'h100, 1'b0, 2'd2, 32'h0);
    run_queue();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_back_to_back();
    test_wait_states();
    test_errors();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
